s1_tx: RTL and testbench



---
 rtl/s1s2_pkg.sv | 21 ++
 rtl/s1_col_buf.sv | 38 +++
 rtl/s1_tx.sv | 126 ++++++++++++
 tb/tb_s1_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s1s2_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// s1s2_pkg : frame geometry and FSM states shared by S1 and S2
// rev 1.0
// ------------------------------------------------------------------
package s1s2_pkg;

  localparam int NWORDS    = 18;
  localparam int WORD_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int FRAME_LEN = ADDR_W + NWORDS;

  typedef enum logic [1:0] {
    READ = 2'd0,
    SEND = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/s1_col_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// s1_col_buf : row-written register file with a single column-bit read
// rev 1.0
// ------------------------------------------------------------------
module s1_col_buf #(
  parameter int NWORDS = s1s2_pkg::NWORDS,
  parameter int WORD_W = s1s2_pkg::WORD_W,
  parameter int ROW_W  = $clog2(NWORDS + 1),
  parameter int COL_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ROW_W-1:0]  wrow,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ROW_W-1:0]  rrow,
  input  logic [COL_W-1:0]  rcol,
  output logic              rbit
);

  localparam logic [ROW_W-1:0] ROWS = ROW_W'(NWORDS);

  logic [WORD_W-1:0] r_mem [NWORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NWORDS; i++) r_mem[i] <= '0;
    end else if (we && (wrow < ROWS)) begin
      r_mem[wrow] <= wdata;
    end
  end

  // Rows past the end read as 0 while the address bits are being sent.
  assign rbit = (rrow < ROWS) ? r_mem[rrow][rcol] : 1'b0;

endmodule
`default_nettype wire

// File: rtl/s1_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// s1_tx : snapshots RB1 and sends its bit-transposed columns to S2
// rev 1.0
// ------------------------------------------------------------------
module s1_tx #(
  parameter int NWORDS = s1s2_pkg::NWORDS,
  parameter int WORD_W = s1s2_pkg::WORD_W,
  parameter int ADDR_W = s1s2_pkg::ADDR_W,
  parameter int TAIL   = 2,
  parameter int ROW_W  = $clog2(NWORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              RB1_RW,
  output logic [ROW_W-1:0]  RB1_A,
  output logic [WORD_W-1:0] RB1_D,
  input  logic [WORD_W-1:0] RB1_Q,
  output logic              sen,
  output logic              sd,
  output logic              S1_done
);

  import s1s2_pkg::state_t;
  import s1s2_pkg::READ;
  import s1s2_pkg::SEND;
  import s1s2_pkg::DONE;

  localparam int FRAME_LEN = ADDR_W + NWORDS;
  localparam int BIT_W     = $clog2(FRAME_LEN);
  localparam int TAIL_W    = (TAIL > 1) ? $clog2(TAIL) : 1;

  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(NWORDS - 1);
  localparam logic [ROW_W-1:0]  READ_LAST  = ROW_W'(NWORDS);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0]  ADDR_BITS  = BIT_W'(ADDR_W);
  localparam logic [ADDR_W-1:0] FRAME_LAST = '1;
  localparam logic [TAIL_W-1:0] TAIL_LAST  = TAIL_W'(TAIL - 1);

  state_t              r_state;
  logic [ROW_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [ADDR_W-1:0]   r_frame;
  logic [TAIL_W-1:0]   r_tail;

  logic                w_we;
  logic [ROW_W-1:0]    w_wrow;
  logic [ROW_W-1:0]    w_rrow;
  logic [ADDR_W-1:0]   w_addr_sh;
  logic                w_col_bit;
  logic                w_bit;

  assign RB1_RW = 1'b1;
  assign RB1_D  = '0;

  // Q lags the address by one edge, so row r_cnt-1 is on RB1_Q now.
  assign w_we   = (r_state == READ) && (r_cnt != '0);
  assign w_wrow = r_cnt - ROW_W'(1);

  // Data bits go out highest row first: row = (FRAME_LEN-1) - bit index.
  assign w_rrow    = ROW_W'(BIT_LAST - r_bit);
  assign w_addr_sh = r_frame << r_bit;
  assign w_bit     = (r_bit < ADDR_BITS) ? w_addr_sh[ADDR_W-1] : w_col_bit;

  s1_col_buf #(
    .NWORDS (NWORDS),
    .WORD_W (WORD_W),
    .ROW_W  (ROW_W),
    .COL_W  (ADDR_W)
  ) u_col_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .wrow  (w_wrow),
    .wdata (RB1_Q),
    .rrow  (w_rrow),
    .rcol  (r_frame),
    .rbit  (w_col_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= READ;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_frame <= '0;
      r_tail  <= '0;
      RB1_A   <= '0;
      sen     <= 1'b1;
      sd      <= 1'b0;
      S1_done <= 1'b0;
    end else begin
      case (r_state)
        READ: begin
          if (RB1_A != LAST_ROW) RB1_A <= RB1_A + ROW_W'(1);
          r_cnt <= r_cnt + ROW_W'(1);
          if (r_cnt == READ_LAST) r_state <= SEND;
        end
        SEND: begin
          sen <= 1'b0;
          sd  <= w_bit;
          if (r_bit == BIT_LAST) begin
            r_bit   <= '0;
            r_frame <= r_frame + ADDR_W'(1);
            if (r_frame == FRAME_LAST) r_state <= s1s2_pkg::TAIL;
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end
        s1s2_pkg::TAIL: begin
          sen <= 1'b0;
          sd  <= 1'b0;
          if (r_tail == TAIL_LAST) r_state <= DONE;
          else                     r_tail  <= r_tail + TAIL_W'(1);
        end
        DONE: begin
          sen     <= 1'b1;
          sd      <= 1'b0;
          S1_done <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s1_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_s1_tx : scoreboard bench, frames deserialised from sen/sd
// rev 1.0
// ------------------------------------------------------------------
module tb_s1_tx;

  localparam int NW = 18;
  localparam int FL = 21;
  localparam int NF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D;
  logic [7:0] RB1_Q = 8'h00;
  logic       sen;
  logic       sd;
  logic       S1_done;

  logic [7:0]  rb1 [NW];
  logic [20:0] exp_q [$];
  logic [20:0] rx_q [$];
  logic [20:0] shreg = '0;
  logic [20:0] got [NF];
  int          nbits = 0;
  int          rd_idx = 0;
  int          checks = 0;
  int          failures = 0;

  s1_tx dut (
    .clk     (clk),
    .rst     (rst),
    .RB1_RW  (RB1_RW),
    .RB1_A   (RB1_A),
    .RB1_D   (RB1_D),
    .RB1_Q   (RB1_Q),
    .sen     (sen),
    .sd      (sd),
    .S1_done (S1_done)
  );

  always #5 clk = ~clk;

  // RB1: address sampled on the rising edge, data valid after it.
  always @(posedge clk) RB1_Q <= (RB1_A < 5'd18) ? rb1[RB1_A] : 8'h00;

  // S2-style receiver: collect 21 sd bits per frame while sen is low.
  always @(negedge clk) begin
    if (!rst || sen) begin
      nbits = 0;
    end else begin
      shreg = {shreg[19:0], sd};
      nbits++;
      if (nbits == FL) begin
        rx_q.push_back(shreg);
        nbits = 0;
      end
    end
  end

  task automatic push_expected();
    logic [20:0] f;
    for (int k = 0; k < NF; k++) begin
      f[20:18] = 3'(k);
      for (int j = 0; j < NW; j++) f[j] = rb1[j][k];
      exp_q.push_back(f);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    rd_idx = rx_q.size();
    exp_q.delete();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (S1_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({RB1_RW, RB1_A, RB1_D, sen, sd, S1_done} !== {1'b1, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: got rw=%b a=%0d d=%h sen=%b sd=%b done=%b, expected 1 0 00 1 0 0",
               RB1_RW, RB1_A, RB1_D, sen, sd, S1_done);
    end
  endtask

  task automatic test_index_timing();
    int          low;
    int          bad;
    logic [20:0] e;
    apply_reset();
    for (int j = 0; j < NW; j++) rb1[j] = 8'(j);
    push_expected();
    release_rst();
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if (RB1_A !== 5'((n > 17) ? 17 : n)) begin
        failures++;
        $display("FAIL rb1_addr_edge%0d: got %0d expected %0d", n, RB1_A, (n > 17) ? 17 : n);
      end
    end
    checks++;
    if (sen !== 1'b1) begin
      failures++;
      $display("FAIL sen_idle_edge19: got %b expected 1", sen);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sen !== 1'b0) begin
      failures++;
      $display("FAIL sen_fall_edge20: got %b expected 0", sen);
    end
    low = 1;
    for (int n = 21; n < 190; n++) begin
      @(posedge clk);
      #1;
      if (sen === 1'b0 && S1_done === 1'b0) low++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (low != 170) begin
      failures++;
      $display("FAIL sen_low_len: got %0d cycles expected 170", low);
    end
    checks++;
    if ({sen, sd, S1_done} !== 3'b101) begin
      failures++;
      $display("FAIL done_edge190: got sen=%b sd=%b done=%b expected 1 0 1", sen, sd, S1_done);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if ({sen, sd, S1_done, RB1_A} !== {3'b101, 5'd17}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL done_hold: got %0d changed cycles expected 0", bad);
    end
    for (int k = 0; k < NF; k++) begin
      e = exp_q.pop_front();
      got[k] = 'x;
      checks++;
      if (rd_idx >= rx_q.size()) begin
        failures++;
        $display("FAIL idx_frame%0d: got no frame expected %h", k, e);
      end else begin
        got[k] = rx_q[rd_idx];
        rd_idx++;
        if (got[k] !== e) begin
          failures++;
          $display("FAIL idx_frame%0d: got %h expected %h", k, got[k], e);
        end
      end
    end
    checks++;
    if (got[0] !== 21'h02AAAA || got[4] !== 21'h130000) begin
      failures++;
      $display("FAIL idx_const_frames: got f0=%h f4=%h expected 02aaaa 130000", got[0], got[4]);
    end
    checks++;
    if ({got[5][17:0], got[6][17:0], got[7][17:0]} !== 54'd0) begin
      failures++;
      $display("FAIL idx_high_frames: got %h %h %h expected zero data", got[5], got[6], got[7]);
    end
  endtask

  task automatic test_all_ones();
    bit          ok;
    logic [20:0] e;
    logic [20:0] a;
    apply_reset();
    for (int j = 0; j < NW; j++) rb1[j] = 8'hFF;
    push_expected();
    release_rst();
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ones_done: got no S1_done within 400 cycles expected done");
    end
    for (int k = 0; k < NF; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= rx_q.size()) begin
        failures++;
        $display("FAIL ones_frame%0d: got no frame expected %h", k, e);
      end else begin
        a = rx_q[rd_idx];
        rd_idx++;
        if (a !== e) begin
          failures++;
          $display("FAIL ones_frame%0d: got %h expected %h", k, a, e);
        end
      end
    end
    checks++;
    if (rd_idx != rx_q.size()) begin
      failures++;
      $display("FAIL ones_extra: got %0d extra frames expected 0", rx_q.size() - rd_idx);
    end
  endtask

  task automatic test_snapshot();
    bit          ok;
    int          bad;
    logic [20:0] e;
    logic [20:0] a;
    apply_reset();
    for (int j = 0; j < NW; j++) rb1[j] = 8'($urandom_range(0, 255));
    push_expected();
    release_rst();
    ok  = 1'b0;
    bad = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (RB1_RW !== 1'b1) bad++;
      if (i == 40) for (int j = 0; j < NW; j++) rb1[j] = ~rb1[j];
      if (S1_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL snap_rw_done: got done=%b rw_bad=%0d expected done=1 rw_bad=0", ok, bad);
    end
    for (int k = 0; k < NF; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= rx_q.size()) begin
        failures++;
        $display("FAIL snap_frame%0d: got no frame expected %h", k, e);
      end else begin
        a = rx_q[rd_idx];
        rd_idx++;
        if (a !== e) begin
          failures++;
          $display("FAIL snap_frame%0d: got %h expected %h", k, a, e);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit          ok;
    logic [20:0] e;
    logic [20:0] a;
    apply_reset();
    for (int j = 0; j < NW; j++) rb1[j] = 8'($urandom_range(0, 255));
    push_expected();
    release_rst();
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({RB1_RW, RB1_A, RB1_D, sen, sd, S1_done} !== {1'b1, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort_values: got rw=%b a=%0d d=%h sen=%b sd=%b done=%b, expected 1 0 00 1 0 0",
               RB1_RW, RB1_A, RB1_D, sen, sd, S1_done);
    end
    repeat (3) @(posedge clk);
    rd_idx = rx_q.size();
    exp_q.delete();
    for (int j = 0; j < NW; j++) rb1[j] = 8'($urandom_range(0, 255));
    push_expected();
    release_rst();
    repeat (19) @(posedge clk);
    #1;
    checks++;
    if (sen !== 1'b1) begin
      failures++;
      $display("FAIL restart_edge19: got sen=%b expected 1", sen);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sen !== 1'b0) begin
      failures++;
      $display("FAIL restart_edge20: got sen=%b expected 0", sen);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL restart_done: got no S1_done within 400 cycles expected done");
    end
    for (int k = 0; k < NF; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= rx_q.size()) begin
        failures++;
        $display("FAIL restart_frame%0d: got no frame expected %h", k, e);
      end else begin
        a = rx_q[rd_idx];
        rd_idx++;
        if (a !== e) begin
          failures++;
          $display("FAIL restart_frame%0d: got %h expected %h", k, a, e);
        end
      end
    end
  endtask

  initial begin
    for (int j = 0; j < NW; j++) rb1[j] = 8'h00;
    test_reset();
    test_index_timing();
    test_all_ones();
    test_snapshot();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
